// File: rtl/pipelined_prefix_adder.sv
// Pipelined Sklansky adder/subtractor with carry-in/out, overflow and zero flags; latency PIPE_DEPTH cycles, 1/cycle.
// Backpressure: a stalled output freezes every stage (no bubble compression); in_ready depends only on out_valid/out_ready.
module pipelined_prefix_adder #(
  parameter int WIDTH      = 16,
  parameter int PIPE_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  // Column 0 carries c_eff (g=c_eff, p=0); column i+1 is operand bit i.
  localparam int N   = WIDTH + 1;
  localparam int L   = $clog2(WIDTH + 1);
  localparam int DIV = (PIPE_DEPTH > 1) ? PIPE_DEPTH - 1 : 1;

  function automatic bit is_bnd(input int lvl);
    for (int s = 0; s < PIPE_DEPTH - 1; s++) begin
      if ((s * L) / DIV == lvl) return 1'b1;
    end
    return 1'b0;
  endfunction

  logic             adv;
  logic [WIDTH-1:0] b_eff;

  assign adv      = ~(out_valid & ~out_ready);
  assign in_ready = adv;
  assign b_eff    = sub ? ~b : b;

  for (genvar l = 0; l < L; l++) begin : g_lvl
    logic [N-1:0]     c_p, c_g, r_p, r_g;
    logic [WIDTH-1:0] c_x, r_x;
    logic             c_v, r_v;

    if (l == 0) begin : g_src
      assign c_p = {a | b_eff, 1'b0};
      assign c_g = {a & b_eff, sub | cin};
      assign c_x = a ^ b_eff;
      assign c_v = in_valid;
    end else begin : g_src
      assign c_x = g_lvl[l-1].r_x;
      assign c_v = g_lvl[l-1].r_v;
      for (genvar i = 0; i < N; i++) begin : g_col
        if (((i >> (l - 1)) & 1) == 1) begin : g_cell
          localparam int J = ((i >> l) << l) + (1 << (l - 1)) - 1;
          assign c_p[i] = g_lvl[l-1].r_p[i] & g_lvl[l-1].r_p[J];
          assign c_g[i] = g_lvl[l-1].r_g[i] | (g_lvl[l-1].r_p[i] & g_lvl[l-1].r_g[J]);
        end else begin : g_pass
          assign c_p[i] = g_lvl[l-1].r_p[i];
          assign c_g[i] = g_lvl[l-1].r_g[i];
        end
      end
    end

    if (is_bnd(l)) begin : g_reg
      logic [N-1:0]     p_q, g_q;
      logic [WIDTH-1:0] x_q;
      logic             v_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_q <= '0;
          g_q <= '0;
          x_q <= '0;
          v_q <= 1'b0;
        end else if (adv) begin
          p_q <= c_p;
          g_q <= c_g;
          x_q <= c_x;
          v_q <= c_v;
        end
      end
      assign r_p = p_q;
      assign r_g = g_q;
      assign r_x = x_q;
      assign r_v = v_q;
    end else begin : g_wire
      assign r_p = c_p;
      assign r_g = c_g;
      assign r_x = c_x;
      assign r_v = c_v;
    end
  end

  // Last level only needs group generates; column i then holds the carry into bit i.
  logic [N-1:0] f_g;
  for (genvar i = 0; i < N; i++) begin : g_fin
    if (((i >> (L - 1)) & 1) == 1) begin : g_cell
      localparam int J = (1 << (L - 1)) - 1;
      assign f_g[i] = g_lvl[L-1].r_g[i] | (g_lvl[L-1].r_p[i] & g_lvl[L-1].r_g[J]);
    end else begin : g_pass
      assign f_g[i] = g_lvl[L-1].r_g[i];
    end
  end

  logic unused_p;
  assign unused_p = ^g_lvl[L-1].r_p;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             valid_q, cout_q, ovf_q, zero_q;

  assign sum_d = g_lvl[L-1].r_x ^ f_g[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (adv) begin
      valid_q <= g_lvl[L-1].r_v;
      sum_q   <= sum_d;
      cout_q  <= f_g[WIDTH];
      ovf_q   <= f_g[WIDTH] ^ f_g[WIDTH-1];
      zero_q  <= ~|sum_d;
    end
  end

  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed + random bench for pipelined_prefix_adder (WIDTH=16, PIPE_DEPTH=2) with a result scoreboard.
module tb_pipelined_prefix_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        cin, sub, cout, ovf, zero;

  int total = 0;
  int bad   = 0;
  logic [18:0] sbq[$];
  logic [1:0]  mv;   // expected valid occupancy: mv[0] stage 0, mv[1] output stage

  pipelined_prefix_adder #(.WIDTH(16), .PIPE_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] model_res(input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic s);
    logic [15:0] be;
    logic [16:0] t;
    logic        o;
    be = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, be} + {16'b0, (s | c)};
    o  = (x[15] == be[15]) && (t[15] != x[15]);
    return {t[15:0], t[16], o, (t[15:0] == 16'h0000)};
  endfunction

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // One cycle: drive at negedge, check outputs, update scoreboard and occupancy model.
  task automatic tick(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                      input logic c, input logic s, input logic r,
                      input logic [18:0] e, output logic acc);
    logic stall;
    @(negedge clk);
    in_valid = v; a = aa; b = bb; cin = c; sub = s; out_ready = r;
    #1;
    stall = mv[1] & ~r;
    chk("out_valid", {18'b0, out_valid}, {18'b0, mv[1]});
    chk("in_ready", {18'b0, in_ready}, {18'b0, ~stall});
    if (mv[1] && sbq.size() > 0) begin
      chk(r ? "result" : "held", {sum, cout, ovf, zero}, sbq[0]);
      if (r) void'(sbq.pop_front());
    end
    if (!stall) begin
      if (v) sbq.push_back(e);
      mv = {mv[0], v};
    end
    acc = v & ~stall;
  endtask

  initial begin
    logic acc;
    int   k, cyc;
    logic [15:0] ra, rb;
    logic rc, rs, rv, rr;

    mv = 2'b00;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {18'b0, out_valid}, 19'h0);
    chk("rst_flags_sum", {sum, cout, ovf, zero}, 19'h0);
    chk("rst_in_ready", {18'b0, in_ready}, 19'h1);
    @(negedge clk);
    rst = 1'b0;

    // Directed arithmetic corner cases with literal expectations {sum, cout, ovf, zero}.
    tick(1, 16'hFFFF, 16'h0000, 1, 0, 1, {16'h0000, 1'b1, 1'b0, 1'b1}, acc);
    tick(1, 16'h8000, 16'h0001, 0, 1, 1, {16'h7FFF, 1'b1, 1'b1, 1'b0}, acc);
    tick(1, 16'h0003, 16'h0005, 1, 1, 1, {16'hFFFE, 1'b0, 1'b0, 1'b0}, acc);
    tick(1, 16'h7FFF, 16'h0001, 0, 0, 1, {16'h8000, 1'b0, 1'b1, 1'b0}, acc);
    tick(0, 16'h0000, 16'h0000, 0, 0, 1, 19'h0, acc);
    tick(1, 16'h1234, 16'h1234, 0, 1, 1, {16'h0000, 1'b1, 1'b0, 1'b1}, acc);
    tick(1, 16'hFFFF, 16'hFFFF, 1, 0, 1, {16'hFFFF, 1'b1, 1'b0, 1'b0}, acc);
    repeat (3) tick(0, 16'h0, 16'h0, 0, 0, 1, 19'h0, acc);

    // Backpressure: five bundles (i, i+1), output blocked for three cycles.
    k = 0; cyc = 0;
    while (k < 5 && cyc < 40) begin
      tick(1, 16'(k), 16'(k + 1), 0, 0, !(cyc >= 2 && cyc < 5),
           model_res(16'(k), 16'(k + 1), 0, 0), acc);
      if (acc) k++;
      cyc++;
    end
    chk("bp_all_accepted", 19'(k), 19'd5);
    repeat (4) tick(0, 16'h0, 16'h0, 0, 0, 1, 19'h0, acc);
    chk("bp_drained", 19'(sbq.size()), 19'd0);

    // Reset with two bundles in flight.
    tick(1, 16'h1234, 16'h1111, 0, 0, 1, model_res(16'h1234, 16'h1111, 0, 0), acc);
    tick(1, 16'h0F0F, 16'h0101, 1, 0, 1, model_res(16'h0F0F, 16'h0101, 1, 0), acc);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {18'b0, out_valid}, 19'h0);
    chk("midrst_sum_flags", {sum, cout, ovf, zero}, 19'h0);
    sbq.delete();
    mv = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) tick(0, 16'h0, 16'h0, 0, 0, 1, 19'h0, acc);

    // Random traffic with random backpressure.
    for (int n = 0; n < 400; n++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 4) != 0); rr = ($urandom_range(0, 3) != 0);
      tick(rv, ra, rb, rc, rs, rr, model_res(ra, rb, rc, rs), acc);
    end
    repeat (4) tick(0, 16'h0, 16'h0, 0, 0, 1, 19'h0, acc);
    chk("sb_empty", 19'(sbq.size()), 19'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
